// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command engine.
// Pure definitions: no latency, no flow control.
// State encoding, default opcodes and the buffer index-width helper.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_LEN,
        GET_DATA,
        DISPLAY,
        TX_LEN,
        TX_DATA
    } state_e;

    localparam logic [7:0] OP_READ_DFLT  = 8'h2A;
    localparam logic [7:0] OP_WRITE_DFLT = 8'h45;

    // At least one address bit so a single-entry buffer still has a legal port.
    function automatic int idx_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/uart_cmd_buffer.sv
// Payload store: DEPTH x DATA_W register file, one synchronous write, one combinational read.
// Write lands on the next edge; read is same-cycle.
// No flow control: the FSM guarantees legal addresses. Contents survive reset.
module uart_cmd_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/uart_cmd_fsm.sv
// Framed UART command engine (WRITE len+payload -> display, READ -> stream back); UART_CMD_TIMEOUT_EN adds a receive timeout.
// Latency: recv to state change 1 cycle; last payload word to first display_valid 1 cycle; send registered after the tx_ready cycle.
// Backpressure: transmit stalls while tx_ready=0; display never stalls; words received while busy are dropped with an error pulse.
module uart_cmd_fsm
    import uart_cmd_pkg::*;
#(
    parameter int          DATA_W   = 8,
    parameter int          DEPTH    = 16,
    parameter logic [7:0]  OP_READ  = OP_READ_DFLT,
    parameter logic [7:0]  OP_WRITE = OP_WRITE_DFLT
`ifdef UART_CMD_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYC = 1000
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              recv,
    input  logic [DATA_W-1:0] uart_rx,
    input  logic              tx_ready,
    output logic              send,
    output logic [DATA_W-1:0] uart_tx,
    output logic              display_valid,
    output logic [DATA_W-1:0] display_data,
    output logic              busy,
    output logic              error
);

    localparam int IDX_W = idx_w(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [DATA_W-1:0] OP_RD_W   = DATA_W'(OP_READ);
    localparam logic [DATA_W-1:0] OP_WR_W   = DATA_W'(OP_WRITE);
    localparam logic [DATA_W:0]   DEPTH_LIM = (DATA_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  index_q, index_d;
    logic              send_q, send_d;
    logic [DATA_W-1:0] uart_tx_q, uart_tx_d;
    logic              display_valid_q, display_valid_d;
    logic [DATA_W-1:0] display_data_q, display_data_d;
    logic              error_q, error_d;

    logic              buf_we;
    logic [IDX_W-1:0]  buf_waddr;
    logic [IDX_W-1:0]  buf_raddr;
    logic [DATA_W-1:0] buf_rdat;
    logic              len_ok;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0]  tmo_q, tmo_d;
`endif

    assign len_ok = (uart_rx != '0) && ({1'b0, uart_rx} <= DEPTH_LIM);

    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        index_d         = index_q;
        send_d          = 1'b0;
        uart_tx_d       = uart_tx_q;
        display_valid_d = 1'b0;
        display_data_d  = display_data_q;
        error_d         = 1'b0;
        buf_we          = 1'b0;
        buf_waddr       = index_q[IDX_W-1:0];
        buf_raddr       = index_q[IDX_W-1:0];

        case (state_q)
            IDLE: begin
                if (recv) begin
                    if (uart_rx == OP_WR_W) begin
                        state_d = GET_LEN;
                    end else if (uart_rx == OP_RD_W) begin
                        state_d = TX_LEN;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            GET_LEN: begin
                if (recv) begin
                    if (len_ok) begin
                        count_d = CNT_W'(uart_rx);
                        index_d = '0;
                        state_d = GET_DATA;
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            GET_DATA: begin
                // Pre-fetch word 0 so the first display word is registered on the last recv.
                buf_raddr = '0;
                if (recv) begin
                    buf_we  = 1'b1;
                    index_d = index_q + CNT_W'(1);
                    if (index_q == count_q - CNT_W'(1)) begin
                        state_d         = DISPLAY;
                        index_d         = CNT_W'(1);
                        display_valid_d = 1'b1;
                        display_data_d  = (index_q == '0) ? uart_rx : buf_rdat;
                    end
                end
            end
            DISPLAY: begin
                // index_q counts words already presented on display_data.
                if (index_q == count_q) begin
                    state_d = IDLE;
                    index_d = '0;
                end else begin
                    display_valid_d = 1'b1;
                    display_data_d  = buf_rdat;
                    index_d         = index_q + CNT_W'(1);
                end
                if (recv) begin
                    error_d = 1'b1;
                end
            end
            TX_LEN: begin
                if (tx_ready) begin
                    send_d    = 1'b1;
                    uart_tx_d = DATA_W'(count_q);
                    index_d   = '0;
                    state_d   = (count_q == '0) ? IDLE : TX_DATA;
                end
                if (recv) begin
                    error_d = 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_ready) begin
                    send_d    = 1'b1;
                    uart_tx_d = buf_rdat;
                    index_d   = index_q + CNT_W'(1);
                    if (index_q == count_q - CNT_W'(1)) begin
                        state_d = IDLE;
                        index_d = '0;
                    end
                end
                if (recv) begin
                    error_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef UART_CMD_TIMEOUT_EN
        tmo_d = '0;
        if ((state_q == GET_LEN || state_q == GET_DATA) && !recv) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                error_d = 1'b1;
                state_d = IDLE;
                count_d = '0;
                index_d = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            count_q         <= '0;
            index_q         <= '0;
            send_q          <= 1'b0;
            uart_tx_q       <= '0;
            display_valid_q <= 1'b0;
            display_data_q  <= '0;
            error_q         <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
            tmo_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            index_q         <= index_d;
            send_q          <= send_d;
            uart_tx_q       <= uart_tx_d;
            display_valid_q <= display_valid_d;
            display_data_q  <= display_data_d;
            error_q         <= error_d;
`ifdef UART_CMD_TIMEOUT_EN
            tmo_q           <= tmo_d;
`endif
        end
    end

    uart_cmd_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (IDX_W)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (buf_waddr),
        .wr_dat  (uart_rx),
        .rd_addr (buf_raddr),
        .rd_dat  (buf_rdat)
    );

    assign send          = send_q;
    assign uart_tx       = uart_tx_q;
    assign display_valid = display_valid_q;
    assign display_data  = display_data_q;
    assign busy          = (state_q != IDLE);
    assign error         = error_q;

endmodule

// File: tb/tb_uart_cmd_fsm.sv
// Directed bench for uart_cmd_fsm: write/display, readback with and without stalls, protocol errors, reset abort.
module tb_uart_cmd_fsm;

    logic       clk;
    logic       reset;
    logic       recv;
    logic [7:0] uart_rx;
    logic       tx_ready;
    logic       send;
    logic [7:0] uart_tx;
    logic       display_valid;
    logic [7:0] display_data;
    logic       busy;
    logic       error;

    int n_cmp = 0;
    int n_bad = 0;
    int err_seen = 0;
    int overlap = 0;

    logic [7:0] exp_w [16];
    int         exp_n;

    uart_cmd_fsm #(
        .DATA_W (8),
        .DEPTH  (16)
`ifdef UART_CMD_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (20)
`endif
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .recv          (recv),
        .uart_rx       (uart_rx),
        .tx_ready      (tx_ready),
        .send          (send),
        .uart_tx       (uart_tx),
        .display_valid (display_valid),
        .display_data  (display_data),
        .busy          (busy),
        .error         (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs settle after the rising edge, so this sees the cycle just ended.
    always @(posedge clk) begin
        if (error) err_seen++;
        if (send && display_valid) overlap++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_recv(input logic [7:0] w);
        recv    = 1'b1;
        uart_rx = w;
        @(negedge clk);
        recv    = 1'b0;
        uart_rx = 8'h00;
    endtask

    // Expects the length word then exp_n payload words on consecutive cycles.
    task automatic rb_stream(input string tag);
        tx_ready = 1'b1;
        for (int i = 0; i <= exp_n; i++) begin
            @(negedge clk);
            chk({tag, "_send"}, send, 1);
            chk({tag, "_word"}, uart_tx, (i == 0) ? exp_n : exp_w[i-1]);
        end
        tx_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_send_end"}, send, 0);
        chk({tag, "_busy_end"}, busy, 0);
    endtask

    task automatic readback(input string tag);
        tx_ready = 1'b1;
        do_recv(8'h2A);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_no_send_yet"}, send, 0);
        rb_stream(tag);
    endtask

    initial begin
        int e0;
        int j;
        logic [7:0] seq [4];
        reset = 1'b1; recv = 1'b0; uart_rx = 8'h00; tx_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_send", send, 0);
        chk("rst_dv", display_valid, 0);
        chk("rst_err", error, 0);
        chk("rst_tx", uart_tx, 0);
        chk("rst_dd", display_data, 0);
        chk("rst_busy", busy, 0);

        // Write 3 words and watch them replay.
        e0 = err_seen;
        do_recv(8'h45);
        chk("wr_busy_len", busy, 1);
        do_recv(8'h03);
        do_recv(8'h11);
        do_recv(8'h22);
        chk("wr_no_dv_early", display_valid, 0);
        do_recv(8'h33);
        chk("disp0_v", display_valid, 1); chk("disp0_d", display_data, 8'h11);
        @(negedge clk);
        chk("disp1_v", display_valid, 1); chk("disp1_d", display_data, 8'h22);
        @(negedge clk);
        chk("disp2_v", display_valid, 1); chk("disp2_d", display_data, 8'h33);
        @(negedge clk);
        chk("disp_end_v", display_valid, 0);
        chk("disp_end_busy", busy, 0);
        @(negedge clk);
        chk("wr_no_err", err_seen - e0, 0);
        exp_n = 3; exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33;

        readback("rb1");

        // Readback with tx_ready toggling: sends only follow ready cycles.
        seq[0] = 8'h03; seq[1] = 8'h11; seq[2] = 8'h22; seq[3] = 8'h33;
        tx_ready = 1'b0;
        do_recv(8'h2A);
        j = 0;
        for (int k = 0; k < 8; k++) begin
            tx_ready = k[0];
            @(negedge clk);
            chk("tog_send", send, k[0]);
            if (k[0]) begin
                chk("tog_word", uart_tx, seq[j]);
                j++;
            end
        end
        tx_ready = 1'b0;
        @(negedge clk);
        chk("tog_busy_end", busy, 0);

        // Protocol errors leave the stored frame intact.
        do_recv(8'h99);
        chk("bad_op_err", error, 1); chk("bad_op_busy", busy, 0);
        @(negedge clk);
        chk("bad_op_err_clr", error, 0);
        readback("rb_badop");

        do_recv(8'h45);
        do_recv(8'h00);
        chk("len0_err", error, 1); chk("len0_busy", busy, 0);
        readback("rb_len0");

        do_recv(8'h45);
        do_recv(8'h11);
        chk("len17_err", error, 1); chk("len17_busy", busy, 0);
        readback("rb_len17");

        // Overrun while waiting on the transmitter.
        tx_ready = 1'b0;
        do_recv(8'h2A);
        do_recv(8'h55);
        chk("ovr_err", error, 1); chk("ovr_busy", busy, 1); chk("ovr_send", send, 0);
        rb_stream("rb_ovr");

        // Single-word frame: first display word comes straight from the last recv.
        do_recv(8'h45);
        do_recv(8'h01);
        do_recv(8'h5A);
        chk("one_v", display_valid, 1); chk("one_d", display_data, 8'h5A);
        @(negedge clk);
        chk("one_end_v", display_valid, 0); chk("one_end_busy", busy, 0);
        exp_n = 1; exp_w[0] = 8'h5A;
        readback("rb_one");

        // Word received during display is dropped, display carries on.
        do_recv(8'h45);
        do_recv(8'h02);
        do_recv(8'hA1);
        do_recv(8'hB2);
        chk("d2_0", display_data, 8'hA1);
        do_recv(8'h77);
        chk("d2_err", error, 1); chk("d2_1v", display_valid, 1); chk("d2_1", display_data, 8'hB2);
        @(negedge clk);
        chk("d2_end_v", display_valid, 0); chk("d2_end_busy", busy, 0);
        exp_n = 2; exp_w[0] = 8'hA1; exp_w[1] = 8'hB2;
        readback("rb_two");

        // Reset mid-frame clears count.
        do_recv(8'h45);
        do_recv(8'h04);
        do_recv(8'hAA);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_busy", busy, 0); chk("mrst_send", send, 0); chk("mrst_dv", display_valid, 0);
        chk("mrst_err", error, 0); chk("mrst_tx", uart_tx, 0); chk("mrst_dd", display_data, 0);
        exp_n = 0;
        readback("rb_rst");

`ifdef UART_CMD_TIMEOUT_EN
        begin
            int waited;
            bit hit;
            do_recv(8'h45);
            do_recv(8'h02);
            do_recv(8'h10);
            chk("tmo_busy", busy, 1);
            waited = 0; hit = 0;
            for (int c = 0; c < 40 && !hit; c++) begin
                @(negedge clk);
                waited++;
                if (error) hit = 1;
            end
            chk("tmo_hit", hit, 1);
            chk("tmo_cycles", waited, 20);
            chk("tmo_busy_end", busy, 0);
            exp_n = 0;
            readback("rb_tmo");
        end
`endif

        chk("no_send_disp_overlap", overlap, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_fsm.md
Name: uart_cmd_fsm

Overview:
Parametrised command engine between the UART receiver/transmitter and the board display logic. It replaces the fixed single-byte IDLE/UART_TX/UART_RX/DISPLAY controller with a framed protocol:
- WRITE opcode, then a length word, then that many payload words stored in a DEPTH-entry buffer and replayed to the display.
- READ opcode: the stored buffer is streamed back over the transmitter with a ready handshake.

Parameters:
- DATA_W, 8: width of the rx/tx/display words; must be >= 8.
- DEPTH, 16: payload buffer entries; must be >= 1 and a power of two.
- OP_READ, 8'h2A: opcode that starts a readback; zero-extended to DATA_W.
- OP_WRITE, 8'h45: opcode that starts a payload write; zero-extended to DATA_W.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- recv  in  1  one-cycle strobe: uart_rx holds a valid received word.
- uart_rx  in  DATA_W  received word, sampled only when recv=1.
- tx_ready  in  1  transmitter can accept a word this cycle.
- send  out  1  one-cycle strobe: uart_tx holds a word to transmit.
- uart_tx  out  DATA_W  word to transmit, valid when send=1.
- display_valid  out  1  display_data valid this cycle.
- display_data  out  DATA_W  payload word for the display.
- busy  out  1  high in every state except IDLE.
- error  out  1  one-cycle pulse on any protocol error.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; send, display_valid, error=0; uart_tx, display_data=0; count, index=0. Buffer contents are not cleared. A reset in any state aborts the operation with no further output.
- States: IDLE, GET_LEN, GET_DATA, DISPLAY, TX_LEN, TX_DATA.
- IDLE:
  - recv with uart_rx==OP_WRITE -> GET_LEN.
  - recv with uart_rx==OP_READ -> TX_LEN.
  - recv with any other value -> error pulse next cycle; stay in IDLE.
- GET_LEN: on recv, L=uart_rx as unsigned.
  - 1<=L<=DEPTH: count<=L, index<=0 -> GET_DATA.
  - L==0 or L>DEPTH: error pulse, count unchanged -> IDLE.
- GET_DATA: each recv writes buf[index]<=uart_rx and increments index. The recv that writes index==count-1 -> DISPLAY with index<=0.
- DISPLAY: one word per cycle, no stall. display_valid=1 and display_data=buf[index] for count consecutive cycles, then -> IDLE. The first display_valid appears on the cycle after the last payload recv.
- TX_LEN: send=1 and uart_tx=count on the first cycle with tx_ready=1 -> TX_DATA with index<=0. If count==0, go directly to IDLE after sending the length word.
- TX_DATA: on each cycle with tx_ready=1, send=1 and uart_tx=buf[index], index++. After the word at count-1 -> IDLE. When tx_ready=0, send=0 and the state holds.
- recv during DISPLAY, TX_LEN or TX_DATA: word dropped, error pulse, operation continues.
- send and display_valid are registered and never high together. error can coincide with them.
- Latency:
  - recv to state change: 1 cycle.
  - Last payload recv to first display_valid: 1 cycle.
  - tx_ready to send: same-cycle decision, registered output.

Optional Feature:
- Macro UART_CMD_TIMEOUT_EN, with parameter TIMEOUT_CYC (default 1000).
- Defined: a counter runs in GET_LEN/GET_DATA and clears on each recv. When it reaches TIMEOUT_CYC with no recv: error pulse, state -> IDLE, count=0.
- Undefined: no counter is present; the FSM waits indefinitely in GET_LEN/GET_DATA.

Decomposition:
- Package uart_cmd_pkg: state enum, OP_READ/OP_WRITE default constants, and a clog2-based index-width helper.
- Sub-module uart_cmd_buffer: DEPTH x DATA_W register file with one synchronous write port and one combinational read port. The FSM owns all counters.

Test Plan:
- Write: reset 2 cycles; recv 0x45, 0x03, 0x11, 0x22, 0x33 -> display_valid for 3 consecutive cycles with 0x11, 0x22, 0x33; busy returns to 0; error never pulses.
- Readback after the write: recv 0x2A with tx_ready=1 -> send pulses on 4 consecutive cycles with 0x03, 0x11, 0x22, 0x33. Repeat with tx_ready toggled every other cycle -> same sequence, with send only on ready cycles.
- Errors:
  - recv 0x99 in IDLE -> error pulse, state stays IDLE.
  - recv 0x45 then 0x00 -> error pulse, IDLE.
  - recv 0x45 then 0x11 with DEPTH=16 -> error pulse, IDLE.
  - In all three cases a following readback still returns the prior count and data.
- Overrun: recv 0x2A with tx_ready=0, then recv 0x55 -> error pulse; subsequent tx_ready=1 still sends the unmodified buffer.
- Reset mid-op: recv 0x45, 0x04, 0xAA, then assert reset -> all outputs 0, state IDLE; then recv 0x2A -> a single send of 0x00.
- UART_CMD_TIMEOUT_EN with TIMEOUT_CYC=20: recv 0x45, 0x02, 0x10, then idle 20 cycles -> error pulse, busy=0.
